// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and hazard unit for the 5-stage integer pipeline. The unit keeps
// a shadow copy of the destination register number, write-enable and load
// flag for every instruction in flight (ID->EX->MEM->WB). It compares these
// against the source registers of younger instructions and produces:
//   - forwarding selects for the ID-stage branch comparator,
//   - forwarding selects for the EX-stage ALU operands and store data,
//   - a load-use / branch-on-load stall request,
//   - a saturating count of stalled cycles.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   pause         global freeze: all internal state holds
//   flush         turn the instruction entering EX into a bubble
//   id_rs/id_rt   ID-stage source register numbers
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   id_is_branch  ID instruction uses the branch comparator
//   id_wr_rn      ID destination register number
//   id_we         ID instruction writes the register file
//   id_is_load    ID instruction is a load
//   cmp_rs_fw     comparator rs select   (ID source vs EX/MEM destination)
//   cmp_rt_fw     comparator rt select
//   alu_rs_fw     ALU rs select          (EX source vs MEM/WB destination)
//   alu_rt_fw     ALU rt select
//   dmem_fw       store-data select, identical to alu_rt_fw
//   stall         hold PC/IF/ID and insert a bubble into EX
//   stall_cnt     saturating count of stalled cycles
//
// Select codes: FW_NOP=0 (register file), FW_ALU=1 (nearest producer),
// FW_MEM=2 (next producer), FW_WB=3 (reserved for the consumer's muxes).
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int RN_W          = 5,
  parameter int FW_W          = 3,
  parameter int CNT_W         = 16,
  parameter int ZERO_REG      = 1,
  parameter int BR_LOAD_STALL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             flush,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_branch,
  input  logic [RN_W-1:0]  id_wr_rn,
  input  logic             id_we,
  input  logic             id_is_load,
  output logic [FW_W-1:0]  cmp_rs_fw,
  output logic [FW_W-1:0]  cmp_rt_fw,
  output logic [FW_W-1:0]  alu_rs_fw,
  output logic [FW_W-1:0]  alu_rt_fw,
  output logic [FW_W-1:0]  dmem_fw,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [FW_W-1:0] FW_NOP = FW_W'(0);
  localparam logic [FW_W-1:0] FW_ALU = FW_W'(1);
  localparam logic [FW_W-1:0] FW_MEM = FW_W'(2);

  // Shadow pipeline records. A bubble is the all-zero record.
  typedef struct packed {
    logic [RN_W-1:0] rs;
    logic [RN_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
    logic [RN_W-1:0] wr_rn;
    logic            we;
    logic            load;
  } ex_rec_t;

  typedef struct packed {
    logic [RN_W-1:0] wr_rn;
    logic            we;
    logic            load;
  } mem_rec_t;

  typedef struct packed {
    logic [RN_W-1:0] wr_rn;
    logic            we;
  } wb_rec_t;

  ex_rec_t  ex_q;
  mem_rec_t mem_q;
  wb_rec_t  wb_q;

  // A source matches a destination only if that destination is actually
  // written; with ZERO_REG set, r0 is hardwired and never forwarded.
  function automatic logic match(input logic [RN_W-1:0] src,
                                 input logic [RN_W-1:0] dst,
                                 input logic            dst_we);
    return (src == dst) && dst_we && !((ZERO_REG != 0) && (src == '0));
  endfunction

  // Nearer (younger) producer wins over the older one.
  function automatic logic [FW_W-1:0] pick(input logic use_src,
                                           input logic hit_near,
                                           input logic hit_far);
    if (!use_src)      return FW_NOP;
    else if (hit_near) return FW_ALU;
    else if (hit_far)  return FW_MEM;
    else               return FW_NOP;
  endfunction

  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic load_use, branch_on_load;

  // NOTE: every signal driven in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    rs_hit_ex      = match(id_rs, ex_q.wr_rn, ex_q.we);
    rt_hit_ex      = match(id_rt, ex_q.wr_rn, ex_q.we);
    rs_hit_mem     = match(id_rs, mem_q.wr_rn, mem_q.we);
    rt_hit_mem     = match(id_rt, mem_q.wr_rn, mem_q.we);

    cmp_rs_fw      = pick(id_use_rs, rs_hit_ex, rs_hit_mem);
    cmp_rt_fw      = pick(id_use_rt, rt_hit_ex, rt_hit_mem);

    alu_rs_fw      = pick(ex_q.use_rs,
                          match(ex_q.rs, mem_q.wr_rn, mem_q.we),
                          match(ex_q.rs, wb_q.wr_rn, wb_q.we));
    alu_rt_fw      = pick(ex_q.use_rt,
                          match(ex_q.rt, mem_q.wr_rn, mem_q.we),
                          match(ex_q.rt, wb_q.wr_rn, wb_q.we));
    dmem_fw        = alu_rt_fw;

    // Load data is not available until the end of MEM, so a consumer right
    // behind a load waits one cycle. The branch comparator sits in ID and
    // needs the value a full stage earlier, hence a second cycle while the
    // load is in MEM.
    load_use       = ex_q.load && ex_q.we &&
                     ((id_use_rs && rs_hit_ex) || (id_use_rt && rt_hit_ex));
    branch_on_load = (BR_LOAD_STALL != 0) && id_is_branch &&
                     mem_q.load && mem_q.we &&
                     ((id_use_rs && rs_hit_mem) || (id_use_rt && rt_hit_mem));
    stall          = load_use || branch_on_load;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, like real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else if (!pause) begin
      wb_q  <= '{wr_rn: mem_q.wr_rn, we: mem_q.we};
      mem_q <= '{wr_rn: ex_q.wr_rn, we: ex_q.we, load: ex_q.load};
      // stall and flush both produce exactly one bubble; the upstream
      // pipeline is responsible for holding the ID fields.
      if (stall || flush) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt,
                  wr_rn: id_wr_rn, we: id_we, load: id_is_load};
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed bench for fwd_hazard_unit. Three instances share one set of
// inputs: the default configuration, one with ZERO_REG=0 and one with a
// 2-bit stall counter. Inputs change 1 ns after a rising edge; outputs are
// compared 1 ns later, well away from the next edge. The stall counter is
// never reset between scenarios, so its expected value accumulates.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, pause, flush;
  logic [4:0] id_rs, id_rt, id_wr_rn;
  logic       id_use_rs, id_use_rt, id_is_branch, id_we, id_is_load;

  logic [2:0]  cmp_rs_fw, cmp_rt_fw, alu_rs_fw, alu_rt_fw, dmem_fw;
  logic        stall;
  logic [15:0] stall_cnt;

  logic [2:0]  z_cmp_rs_fw, z_cmp_rt_fw, z_alu_rs_fw, z_alu_rt_fw, z_dmem_fw;
  logic        z_stall;
  logic [15:0] z_stall_cnt;

  logic [2:0]  c_cmp_rs_fw, c_cmp_rt_fw, c_alu_rs_fw, c_alu_rt_fw, c_dmem_fw;
  logic        c_stall;
  logic [1:0]  c_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_wr_rn(id_wr_rn), .id_we(id_we),
    .id_is_load(id_is_load),
    .cmp_rs_fw(cmp_rs_fw), .cmp_rt_fw(cmp_rt_fw), .alu_rs_fw(alu_rs_fw),
    .alu_rt_fw(alu_rt_fw), .dmem_fw(dmem_fw), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_wr_rn(id_wr_rn), .id_we(id_we),
    .id_is_load(id_is_load),
    .cmp_rs_fw(z_cmp_rs_fw), .cmp_rt_fw(z_cmp_rt_fw), .alu_rs_fw(z_alu_rs_fw),
    .alu_rt_fw(z_alu_rt_fw), .dmem_fw(z_dmem_fw), .stall(z_stall),
    .stall_cnt(z_stall_cnt)
  );

  fwd_hazard_unit #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_wr_rn(id_wr_rn), .id_we(id_we),
    .id_is_load(id_is_load),
    .cmp_rs_fw(c_cmp_rs_fw), .cmp_rt_fw(c_cmp_rt_fw), .alu_rs_fw(c_alu_rs_fw),
    .alu_rt_fw(c_alu_rt_fw), .dmem_fw(c_dmem_fw), .stall(c_stall),
    .stall_cnt(c_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one instruction in ID.
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rs, input logic use_rt,
                        input logic br, input logic [4:0] wr,
                        input logic we, input logic ld);
    id_rs = rs; id_rt = rt; id_use_rs = use_rs; id_use_rt = use_rt;
    id_is_branch = br; id_wr_rn = wr; id_we = we; id_is_load = ld;
  endtask

  task automatic nop_id();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push bubbles through EX, MEM and WB.
  task automatic drain();
    nop_id();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; flush = 1'b0;
    nop_id();

    // ---- reset then idle ----
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_cmp_rs", 32'(cmp_rs_fw), 0);
    check("rst_cmp_rt", 32'(cmp_rt_fw), 0);
    check("rst_alu_rs", 32'(alu_rs_fw), 0);
    check("rst_alu_rt", 32'(alu_rt_fw), 0);
    check("rst_dmem",   32'(dmem_fw), 0);
    check("rst_stall",  32'(stall), 0);
    check("rst_cnt",    32'(stall_cnt), 0);

    // ---- back-to-back ALU dependency: add r3 ; sub rs=r3 ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();                                    // add in EX
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    check("b2b_cmp_rs_ex", 32'(cmp_rs_fw), 1);
    tick();                                    // sub in EX, add in MEM
    nop_id();
    #1;
    check("b2b_alu_rs_mem", 32'(alu_rs_fw), 1);
    drain();

    // add r3 ; nop ; sub rs=r3 -> sub in EX while add is in WB
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    nop_id();
    tick();
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    check("gap_cmp_rs_mem", 32'(cmp_rs_fw), 2);
    tick();
    nop_id();
    #1;
    check("gap_alu_rs_wb", 32'(alu_rs_fw), 2);
    drain();

    // ---- two writers to r5 in EX and MEM: youngest wins ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("prio_cmp_rs", 32'(cmp_rs_fw), 1);
    check("prio_cmp_rt_unused", 32'(cmp_rt_fw), 0);
    drain();

    // ---- writer to r0 ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("r0_zero_reg1", 32'(cmp_rs_fw), 0);
    check("r0_zero_reg0", 32'(z_cmp_rs_fw), 1);
    id_use_rs = 1'b0;
    #1;
    check("r0_zero_reg0_unused", 32'(z_cmp_rs_fw), 0);
    drain();

    // ---- flush alone squashes the entering instruction ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_id(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("flush_cmp_rs", 32'(cmp_rs_fw), 0);
    drain();

    // ---- load-use: lw r4 ; add r9 = r9 + r4 ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();                                    // lw in EX
    set_id(5'd9, 5'd4, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    check("lu_stall_1", 32'(stall), 1);
    check("lu_cmp_rt_ex", 32'(cmp_rt_fw), 1);
    tick();                                    // bubble in EX, lw in MEM
    #1;
    check("lu_stall_2", 32'(stall), 0);
    check("lu_bubble_cmp_rs", 32'(cmp_rs_fw), 0);
    check("lu_cmp_rt_mem", 32'(cmp_rt_fw), 2);
    tick();                                    // add in EX, lw in WB
    nop_id();
    #1;
    check("lu_alu_rt", 32'(alu_rt_fw), 2);
    check("lu_dmem", 32'(dmem_fw), 2);
    check("lu_alu_rs", 32'(alu_rs_fw), 0);
    check("lu_cnt", 32'(stall_cnt), 1);
    drain();

    // ---- branch-on-load: lw r7 ; beq rs=r7 ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    check("bl_stall_1", 32'(stall), 1);
    tick();                                    // lw in MEM, bubble in EX
    #1;
    check("bl_stall_2", 32'(stall), 1);
    check("bl_cmp_rs_mem", 32'(cmp_rs_fw), 2);
    tick();                                    // lw in WB
    #1;
    check("bl_stall_3", 32'(stall), 0);
    check("bl_cnt", 32'(stall_cnt), 3);
    drain();

    // ---- pause during a load-use stall ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    pause = 1'b1;
    tick(); tick();
    #1;
    check("pause_stall", 32'(stall), 1);
    check("pause_cnt", 32'(stall_cnt), 3);
    check("pause_cmp_rt", 32'(cmp_rt_fw), 1);
    pause = 1'b0;
    tick();
    #1;
    check("unpause_stall", 32'(stall), 0);
    check("unpause_cnt", 32'(stall_cnt), 4);
    check("unpause_cmp_rt", 32'(cmp_rt_fw), 2);
    drain();

    // ---- flush together with stall: one bubble ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(5'd9, 5'd4, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("fs_stall", 32'(stall), 1);
    tick();
    flush = 1'b0;
    #1;
    check("fs_bubble_cmp_rs", 32'(cmp_rs_fw), 0);
    check("fs_cmp_rt_mem", 32'(cmp_rt_fw), 2);
    check("fs_cnt", 32'(stall_cnt), 5);
    tick();
    nop_id();
    #1;
    check("fs_alu_rt", 32'(alu_rt_fw), 2);

    // ---- saturation: five stalled cycles so far ----
    check("sat_cnt2", 32'(c_stall_cnt), 3);
    check("sat_cnt16", 32'(stall_cnt), 5);
    drain();

    // ---- reset in the middle of a stall ----
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    check("rs_mid_stall", 32'(stall), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rs_stall", 32'(stall), 0);
    check("rs_cmp_rt", 32'(cmp_rt_fw), 0);
    check("rs_alu_rt", 32'(alu_rt_fw), 0);
    check("rs_cnt", 32'(stall_cnt), 0);
    check("rs_cnt2", 32'(c_stall_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
